// File: rtl/fft_framer_pkg.sv
// Shared definitions for the FFT framer: default sizes, write-FSM state encoding
// and the frame-length normalisation rule.
package fft_framer_pkg;

    localparam int DW_DEF         = 16;
    localparam int DATA_CNT_DEF   = 1024;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int GAP_W          = 19;

    typedef enum logic [1:0] {
        FRM_IDLE  = 2'd0,
        FRM_FRAME = 2'd1,
        FRM_GAP   = 2'd2
    } frm_state_t;

    // 0 selects the maximum length, 1 is promoted to 2, anything above the maximum is clamped.
    function automatic int eff_frame_len(input int frame_len, input int data_cnt);
        if (frame_len == 0)
            return data_cnt;
        else if (frame_len == 1)
            return 2;
        else if (frame_len > data_cnt)
            return data_cnt;
        else
            return frame_len;
    endfunction

endpackage

// File: rtl/fft_framer_fifo.sv
// Synchronous FIFO with a registered head entry; DEPTH counts the head register plus
// the backing store, so exactly DEPTH entries can be held.
module fft_framer_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         full,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         rd_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   mem_cnt_q;
    logic [AW:0]   occupancy;
    logic          pop;
    logic          accept;
    logic          load;
    logic          from_mem;
    logic          bypass;
    logic          mem_push;

    // Full is judged after this cycle's pop, so a simultaneous read frees a slot.
    assign pop       = rd_valid && rd_en;
    assign occupancy = mem_cnt_q + {{AW{1'b0}}, rd_valid};
    assign full      = (occupancy == DEPTH_V) && !pop;
    assign accept    = wr_en && !full;
    assign load      = !rd_valid || pop;
    assign from_mem  = load && (mem_cnt_q != '0);
    assign bypass    = load && (mem_cnt_q == '0) && accept;
    assign mem_push  = accept && !bypass;

    always_ff @(posedge clk) begin
        if (mem_push)
            mem[wptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            mem_cnt_q <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            if (mem_push)
                wptr_q <= wptr_q + 1'b1;
            if (from_mem)
                rptr_q <= rptr_q + 1'b1;
            mem_cnt_q <= mem_cnt_q + {{AW{1'b0}}, mem_push} - {{AW{1'b0}}, from_mem};
            if (load) begin
                if (from_mem) begin
                    rd_data  <= mem[rptr_q];
                    rd_valid <= 1'b1;
                end else if (bypass) begin
                    rd_data  <= wr_data;
                    rd_valid <= 1'b1;
                end else begin
                    rd_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/fft_framer.sv
// Cuts the ADC sample stream into FFT frames with tlast, optional frame decimation,
// and an output FIFO that truncates a frame on overflow to keep tlast aligned.
module fft_framer
    import fft_framer_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int DATA_CNT   = DATA_CNT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DW-1:0]             tdata_s,
    input  logic                      tvalid_s,
    output logic [DW-1:0]             tdata_m,
    output logic                      tvalid_m,
    output logic                      tlast_m,
    input  logic                      tready_m,
    input  logic                      enable,
    input  logic [$clog2(DATA_CNT):0] frame_len,
    input  logic [7:0]                frame_skip,
    output logic                      busy,
    output logic                      ovf_flag,
    output logic [15:0]               ovf_cnt,
    output logic [15:0]               frame_cnt,
    output frm_state_t                state_dbg
);

    localparam int LW = $clog2(DATA_CNT) + 1;

    // Output handshake: {tlast_m,tdata_m} are valid while tvalid_m is high and stay
    // frozen until tready_m is seen high at a clock edge, which pops the entry.
    frm_state_t       state_q, state_d;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    wcnt_q;
    logic [LW-1:0]    eff_len;
    logic [7:0]       skip_q;
    logic [GAP_W-1:0] gap_total_q;
    logic [GAP_W-1:0] gcnt_q;
    logic             trunc_pend_q;
    logic             enable_q;
    logic             enable_rise;
    logic             fifo_full;
    logic             fifo_wr;
    logic             fifo_last;
    logic             drop;
    logic             frame_end;
    logic             gap_end;
    logic             latch;
    logic             pop;
    logic [DW:0]      fifo_rdata;

    assign eff_len     = LW'(eff_frame_len(int'(frame_len), DATA_CNT));
    assign enable_rise = enable && !enable_q;
    assign pop         = tvalid_m && tready_m;
    assign busy        = (state_q != FRM_IDLE);
    assign state_dbg   = state_q;

    always_comb begin
        state_d   = state_q;
        fifo_wr   = 1'b0;
        fifo_last = 1'b0;
        drop      = 1'b0;
        frame_end = 1'b0;
        gap_end   = 1'b0;
        latch     = 1'b0;
        case (state_q)
            FRM_IDLE: begin
                if (enable) begin
                    state_d = FRM_FRAME;
                    latch   = 1'b1;
                end
            end
            FRM_FRAME: begin
                if (tvalid_s) begin
                    if (fifo_full) begin
                        drop = 1'b1;
                    end else begin
                        fifo_wr   = 1'b1;
                        fifo_last = trunc_pend_q || (wcnt_q == len_q - 1'b1);
                        frame_end = fifo_last;
                    end
                end
                // A truncated frame leaves FRAME exactly like a natural one.
                if (frame_end) begin
                    if (skip_q != 8'd0)
                        state_d = FRM_GAP;
                    else if (enable)
                        latch = 1'b1;
                    else
                        state_d = FRM_IDLE;
                end
            end
            FRM_GAP: begin
                if (tvalid_s && (gcnt_q == gap_total_q - 1'b1)) begin
                    gap_end = 1'b1;
                    if (enable) begin
                        state_d = FRM_FRAME;
                        latch   = 1'b1;
                    end else begin
                        state_d = FRM_IDLE;
                    end
                end
            end
            default: state_d = FRM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FRM_IDLE;
            enable_q     <= 1'b0;
            len_q        <= '0;
            skip_q       <= '0;
            gap_total_q  <= '0;
            wcnt_q       <= '0;
            gcnt_q       <= '0;
            trunc_pend_q <= 1'b0;
            ovf_flag     <= 1'b0;
            ovf_cnt      <= '0;
            frame_cnt    <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable;
            if (latch) begin
                len_q       <= eff_len;
                skip_q      <= frame_skip;
                gap_total_q <= GAP_W'(frame_skip) * GAP_W'(eff_len);
            end
            if (frame_end)
                wcnt_q <= '0;
            else if (fifo_wr)
                wcnt_q <= wcnt_q + 1'b1;
            if (frame_end || gap_end)
                gcnt_q <= '0;
            else if ((state_q == FRM_GAP) && tvalid_s)
                gcnt_q <= gcnt_q + 1'b1;
            if (drop)
                trunc_pend_q <= 1'b1;
            else if (fifo_wr)
                trunc_pend_q <= 1'b0;
            // A drop coinciding with the enable rise still registers as one event.
            if (enable_rise) begin
                ovf_flag <= drop;
                ovf_cnt  <= {15'd0, drop};
            end else if (drop) begin
                ovf_flag <= 1'b1;
                if (ovf_cnt != 16'hFFFF)
                    ovf_cnt <= ovf_cnt + 16'd1;
            end
            if (pop && fifo_rdata[DW])
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    fft_framer_fifo #(
        .W    (DW + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (fifo_wr),
        .wr_data ({fifo_last, tdata_s}),
        .full    (fifo_full),
        .rd_en   (tready_m),
        .rd_data (fifo_rdata),
        .rd_valid(tvalid_m)
    );

    assign tdata_m = fifo_rdata[DW-1:0];
    assign tlast_m = fifo_rdata[DW];

endmodule

// File: tb/tb_fft_framer.sv
// Bench for fft_framer: directed framing, decimation, overflow and enable scenarios,
// then randomized back-pressure with a mid-frame reset, against a frame-index model.
module tb_fft_framer;
    import fft_framer_pkg::*;

    localparam int DW         = 16;
    localparam int DATA_CNT   = 1024;
    localparam int FIFO_DEPTH = 4;
    localparam int LW         = $clog2(DATA_CNT) + 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [DW-1:0]     tdata_s = '0;
    logic              tvalid_s = 1'b0;
    logic [DW-1:0]     tdata_m;
    logic              tvalid_m;
    logic              tlast_m;
    logic              tready_m = 1'b1;
    logic              enable = 1'b0;
    logic [LW-1:0]     frame_len = '0;
    logic [7:0]        frame_skip = '0;
    logic              busy;
    logic              ovf_flag;
    logic [15:0]       ovf_cnt;
    logic [15:0]       frame_cnt;
    frm_state_t        state_dbg;

    int checks = 0;
    int errors = 0;
    logic [DW:0] exp_q[$];
    logic rp1 = 1'b1;
    logic rp2 = 1'b1;
    logic stall_prev = 1'b0;
    logic [DW:0] stall_word = '0;

    fft_framer #(
        .DW        (DW),
        .DATA_CNT  (DATA_CNT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tdata_s   (tdata_s),
        .tvalid_s  (tvalid_s),
        .tdata_m   (tdata_m),
        .tvalid_m  (tvalid_m),
        .tlast_m   (tlast_m),
        .tready_m  (tready_m),
        .enable    (enable),
        .frame_len (frame_len),
        .frame_skip(frame_skip),
        .busy      (busy),
        .ovf_flag  (ovf_flag),
        .ovf_cnt   (ovf_cnt),
        .frame_cnt (frame_cnt),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every handshake must match the head of the expected queue,
    // and a stalled word must not change.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", {31'd0, tvalid_m}, 32'd1);
                chk("hold_word", {15'd0, tlast_m, tdata_m}, {15'd0, stall_word});
            end
            if (tvalid_m && tready_m) begin
                chk("out_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0)
                    chk("out_word", {15'd0, tlast_m, tdata_m}, {15'd0, exp_q.pop_front()});
            end
            stall_prev = tvalid_m && !tready_m;
            stall_word = {tlast_m, tdata_m};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_len(input int fl);
        return (fl == 0) ? DATA_CNT : (fl == 1) ? 2 : fl;
    endfunction

    // Sample k (counted from the frame start) is kept when it falls in the first
    // L positions of each L*(S+1) period; the L-th kept one carries tlast.
    task automatic model_push(input int k, input int l, input int s, input logic [DW-1:0] d,
                              inout int lasts);
        int pos;
        pos = k % (l * (s + 1));
        if (pos < l) begin
            exp_q.push_back({pos == l - 1, d});
            if (pos == l - 1)
                lasts++;
        end
    endtask

    task automatic start(input int fl, input int sk);
        frame_len  = LW'(fl);
        frame_skip = 8'(sk);
        enable     = 1'b1;
        step();
    endtask

    task automatic send(input logic [DW-1:0] d);
        tvalid_s = 1'b1;
        tdata_s  = d;
        step();
        tvalid_s = 1'b0;
    endtask

    task automatic rand_cycle(input logic v, input logic [DW-1:0] d);
        logic r;
        r = 1'($urandom_range(0, 1));
        if (!rp1 && !rp2)
            r = 1'b1;
        rp2      = rp1;
        rp1      = r;
        tready_m = r;
        tvalid_s = v;
        tdata_s  = d;
        step();
        tvalid_s = 1'b0;
    endtask

    task automatic run_random(input int n, input int l, input int s, inout int lasts);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            repeat (3) rand_cycle(1'b0, '0);
            d = DW'($urandom_range(0, 65535));
            model_push(i, l, s, d, lasts);
            rand_cycle(1'b1, d);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        tready_m = 1'b1;
        while (exp_q.size() != 0 && n < 5000) begin
            step();
            n++;
        end
        chk(tag, exp_q.size(), 32'd0);
        step();
        step();
    endtask

    initial begin
        int lasts;
        int fl;
        int sk;
        int l;
        int n;
        logic [DW-1:0] d;

        repeat (3) step();
        chk("rst_tvalid", {31'd0, tvalid_m}, 32'd0);
        chk("rst_tlast", {31'd0, tlast_m}, 32'd0);
        chk("rst_tdata", {16'd0, tdata_m}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {15'd0, ovf_flag, ovf_cnt}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        reset_n = 1'b1;
        step();
        chk("idle_state", {30'd0, state_dbg}, {30'd0, FRM_IDLE});

        // Three back-to-back frames of 8, enable dropped inside the last one.
        lasts = 0;
        start(8, 0);
        for (int i = 0; i < 24; i++) begin
            if (i == 20)
                enable = 1'b0;
            model_push(i, 8, 0, DW'(i + 1), lasts);
            send(DW'(i + 1));
        end
        drain("t1_drain");
        chk("t1_frame_cnt", {16'd0, frame_cnt}, 32'd3);
        chk("t1_idle", {30'd0, state_dbg}, {30'd0, FRM_IDLE});

        // Decimation: length 4, two frames skipped.
        start(4, 2);
        for (int i = 0; i < 24; i++) begin
            if (i == 20)
                enable = 1'b0;
            model_push(i, 4, 2, DW'(i + 1), lasts);
            send(DW'(i + 1));
            if (i < 20)
                chk("t2_busy", {31'd0, busy}, 32'd1);
        end
        drain("t2_drain");
        chk("t2_frame_cnt", {16'd0, frame_cnt}, 32'd5);
        chk("t2_busy_end", {31'd0, busy}, 32'd0);

        // frame_len=0 gives DATA_CNT samples per frame.
        start(0, 0);
        for (int i = 0; i < DATA_CNT; i++) begin
            if (i == DATA_CNT - 24)
                enable = 1'b0;
            d = DW'($urandom_range(0, 65535));
            model_push(i, model_len(0), 0, d, lasts);
            send(d);
        end
        drain("t3a_drain");
        chk("t3a_frame_cnt", {16'd0, frame_cnt}, 32'd6);

        // frame_len=1 behaves as 2.
        start(1, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7)
                enable = 1'b0;
            model_push(i, model_len(1), 0, DW'(100 + i), lasts);
            send(DW'(100 + i));
        end
        drain("t3b_drain");
        chk("t3b_frame_cnt", {16'd0, frame_cnt}, 32'd10);

        // Overflow: four entries fit, samples 5..10 are dropped, 11 closes the short frame.
        tready_m = 1'b0;
        start(16, 0);
        for (int i = 1; i <= 10; i++) begin
            if (i <= 4)
                exp_q.push_back({1'b0, DW'(i)});
            send(DW'(i));
        end
        chk("t4_ovf_cnt", {16'd0, ovf_cnt}, 32'd6);
        chk("t4_ovf_flag", {31'd0, ovf_flag}, 32'd1);
        tready_m = 1'b1;
        for (int i = 11; i <= 27; i++) begin
            if (i == 20)
                enable = 1'b0;
            exp_q.push_back({(i == 11) || (i == 27), DW'(i)});
            send(DW'(i));
        end
        drain("t4_drain");
        chk("t4_frame_cnt", {16'd0, frame_cnt}, 32'd12);
        chk("t4_ovf_cnt_hold", {16'd0, ovf_cnt}, 32'd6);

        // Enable dropped mid-frame: the frame still completes, then samples are ignored.
        chk("t5_ovf_sticky", {31'd0, ovf_flag}, 32'd1);
        start(8, 0);
        chk("t5_ovf_flag_clr", {31'd0, ovf_flag}, 32'd0);
        chk("t5_ovf_cnt_clr", {16'd0, ovf_cnt}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (i == 4)
                enable = 1'b0;
            if (i < 8)
                exp_q.push_back({i == 7, DW'(200 + i)});
            send(DW'(200 + i));
        end
        drain("t5_drain");
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_frame_cnt", {16'd0, frame_cnt}, 32'd13);

        // Random back-pressure, reset in the middle of a frame, then a fresh segment.
        fl = $urandom_range(2, 10);
        sk = $urandom_range(0, 2);
        l  = model_len(fl);
        start(fl, sk);
        n = l * (sk + 1) * 2 + 1;
        run_random(n, l, sk, lasts);
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            chk("t6_rst_tvalid", {31'd0, tvalid_m}, 32'd0);
            chk("t6_rst_word", {15'd0, tlast_m, tdata_m}, 32'd0);
            chk("t6_rst_status", {busy, ovf_flag, ovf_cnt, 14'd0}, 32'd0);
            chk("t6_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
            step();
        end
        reset_n = 1'b1;
        fl = $urandom_range(2, 10);
        sk = $urandom_range(0, 2);
        l  = model_len(fl);
        start(fl, sk);
        lasts = 0;
        run_random(l * (sk + 1) * 3 + 2, l, sk, lasts);
        drain("t6_drain");
        chk("t6_frame_cnt", {16'd0, frame_cnt}, 32'(lasts));
        chk("t6_no_ovf", {15'd0, ovf_flag, ovf_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
